apu_sound_mixer: RTL and testbench

- Downstream consumer of the APU channel outputs.
- Takes the four 4-bit channel amplitudes, the per-channel DAC enables, the L/R routing masks and the inverted master volumes.
- Produces a registered signed stereo PCM sample at a fixed sample rate.
- Drives a first-order sigma-delta 1-bit stream per side, which feeds the pad/PWM audio output.

---
 rtl/apu_sound_mixer.sv | 170 +++++++++++++++++
 tb/tb_apu_sound_mixer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apu_sound_mixer.sv
// APU stereo mixer: strobed channel capture, routed sum, volume scale, first-order sigma-delta out.
// Optional VIN fifth input enabled by defining APU_VIN_MIX_EN.
module apu_sound_mixer #(
  parameter int SAMPLE_DIV = 32,
  parameter int PCM_W      = 11
) (
  input  logic                    cclk,
  input  logic                    reset,
  input  logic                    apu_on,
  input  logic [3:0]              ch1_out,
  input  logic [3:0]              ch2_out,
  input  logic [3:0]              ch3_out,
  input  logic [3:0]              ch4_out,
  input  logic                    n_ch1_amp_en,
  input  logic                    n_ch2_amp_en,
  input  logic                    n_ch3_amp_en,
  input  logic                    n_ch4_amp_en,
  input  logic [3:0]              rmixer,
  input  logic [3:0]              lmixer,
  input  logic [2:0]              n_rvolume,
  input  logic [2:0]              n_lvolume,
  input  logic                    r_vin_en,
  input  logic                    l_vin_en,
`ifdef APU_VIN_MIX_EN
  input  logic [3:0]              vin_in,
`endif
  output logic signed [PCM_W-1:0] pcm_l,
  output logic signed [PCM_W-1:0] pcm_r,
  output logic                    pcm_valid,
  output logic                    pdm_l,
  output logic                    pdm_r
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SUM_W = 8;
  localparam int NT    = 5;

  logic [CNT_W-1:0] count_reg;
  logic             strobe;
  assign strobe = (count_reg == CNT_W'(SAMPLE_DIV - 1));

  logic [3:0]    amp [NT];
  logic [NT-1:0] dis;
  logic [NT-1:0] lroute;
  logic [NT-1:0] rroute;

  assign amp[0] = ch1_out;
  assign amp[1] = ch2_out;
  assign amp[2] = ch3_out;
  assign amp[3] = ch4_out;

`ifdef APU_VIN_MIX_EN
  assign amp[4] = vin_in;
  assign dis    = {1'b0, n_ch4_amp_en, n_ch3_amp_en, n_ch2_amp_en, n_ch1_amp_en};
  assign lroute = {l_vin_en, lmixer};
  assign rroute = {r_vin_en, rmixer};
`else
  // Without VIN the fifth term is forced off; the routing bits are deliberately ignored.
  logic unused_vin;
  assign unused_vin = r_vin_en ^ l_vin_en;
  assign amp[4] = 4'd0;
  assign dis    = {1'b1, n_ch4_amp_en, n_ch3_amp_en, n_ch2_amp_en, n_ch1_amp_en};
  assign lroute = {1'b0, lmixer};
  assign rroute = {1'b0, rmixer};
`endif

  logic signed [5:0] term_next [NT];
  genvar gi;
  generate
    for (gi = 0; gi < NT; gi++) begin : g_term
      assign term_next[gi] = dis[gi] ? 6'sd0 : $signed({1'b0, amp[gi], 1'b0}) - 6'sd15;
    end
  endgenerate

  logic [3:0] lvol_next, rvol_next;
  assign lvol_next = {1'b0, ~n_lvolume} + 4'd1;
  assign rvol_next = {1'b0, ~n_rvolume} + 4'd1;

  logic signed [5:0]       term_reg [NT];
  logic [NT-1:0]           lmask_reg, rmask_reg;
  logic [3:0]              lvol_reg, rvol_reg;
  logic                    s1_valid_reg, s2_valid_reg;
  logic signed [SUM_W-1:0] sum_l_reg, sum_r_reg;
  logic signed [SUM_W-1:0] sum_l_next, sum_r_next;
  logic signed [PCM_W-1:0] prod_l, prod_r;
  logic [10:0]             acc_l_reg, acc_r_reg;
  logic [11:0]             sd_l, sd_r;

  always_comb begin
    sum_l_next = '0;
    sum_r_next = '0;
    for (int i = 0; i < NT; i++) begin
      if (lmask_reg[i]) sum_l_next = sum_l_next + SUM_W'(term_reg[i]);
      if (rmask_reg[i]) sum_r_next = sum_r_next + SUM_W'(term_reg[i]);
    end
  end

  // Volumes stay stable through stage 3 because the next strobe is at least 4 cycles away.
  assign prod_l = PCM_W'(sum_l_reg) * PCM_W'($signed({1'b0, lvol_reg}));
  assign prod_r = PCM_W'(sum_r_reg) * PCM_W'($signed({1'b0, rvol_reg}));

  // Offset binary: adding 1024 mod 2048 is a flip of bit 10.
  assign sd_l = {1'b0, acc_l_reg} + {1'b0, ~pcm_l[10], pcm_l[9:0]};
  assign sd_r = {1'b0, acc_r_reg} + {1'b0, ~pcm_r[10], pcm_r[9:0]};

  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      count_reg    <= '0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      for (int i = 0; i < NT; i++) term_reg[i] <= '0;
      lmask_reg    <= '0;
      rmask_reg    <= '0;
      lvol_reg     <= '0;
      rvol_reg     <= '0;
      sum_l_reg    <= '0;
      sum_r_reg    <= '0;
      pcm_l        <= '0;
      pcm_r        <= '0;
      pcm_valid    <= 1'b0;
      acc_l_reg    <= '0;
      acc_r_reg    <= '0;
      pdm_l        <= 1'b0;
      pdm_r        <= 1'b0;
    end else if (!apu_on) begin
      count_reg    <= '0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      for (int i = 0; i < NT; i++) term_reg[i] <= '0;
      lmask_reg    <= '0;
      rmask_reg    <= '0;
      lvol_reg     <= '0;
      rvol_reg     <= '0;
      sum_l_reg    <= '0;
      sum_r_reg    <= '0;
      pcm_l        <= '0;
      pcm_r        <= '0;
      pcm_valid    <= 1'b0;
      acc_l_reg    <= '0;
      acc_r_reg    <= '0;
      pdm_l        <= 1'b0;
      pdm_r        <= 1'b0;
    end else begin
      count_reg    <= strobe ? '0 : count_reg + CNT_W'(1);
      s1_valid_reg <= strobe;
      if (strobe) begin
        for (int i = 0; i < NT; i++) term_reg[i] <= term_next[i];
        lmask_reg <= lroute;
        rmask_reg <= rroute;
        lvol_reg  <= lvol_next;
        rvol_reg  <= rvol_next;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_l_reg <= sum_l_next;
        sum_r_reg <= sum_r_next;
      end
      pcm_valid <= s2_valid_reg;
      if (s2_valid_reg) begin
        pcm_l <= prod_l;
        pcm_r <= prod_r;
      end
      acc_l_reg <= sd_l[10:0];
      acc_r_reg <= sd_r[10:0];
      pdm_l     <= sd_l[11];
      pdm_r     <= sd_r[11];
    end
  end

endmodule

// File: tb/tb_apu_sound_mixer.sv
// Directed self-checking bench for apu_sound_mixer (SAMPLE_DIV = 32, PCM_W = 11).
module tb_apu_sound_mixer;

  logic               cclk = 1'b0;
  logic               reset;
  logic               apu_on;
  logic [3:0]         ch1_out, ch2_out, ch3_out, ch4_out;
  logic               n_ch1_amp_en, n_ch2_amp_en, n_ch3_amp_en, n_ch4_amp_en;
  logic [3:0]         rmixer, lmixer;
  logic [2:0]         n_rvolume, n_lvolume;
  logic               r_vin_en, l_vin_en;
`ifdef APU_VIN_MIX_EN
  logic [3:0]         vin_in;
`endif
  logic signed [10:0] pcm_l, pcm_r;
  logic               pcm_valid, pdm_l, pdm_r;

  int checks = 0;
  int errors = 0;

  apu_sound_mixer dut (
    .cclk(cclk), .reset(reset), .apu_on(apu_on),
    .ch1_out(ch1_out), .ch2_out(ch2_out), .ch3_out(ch3_out), .ch4_out(ch4_out),
    .n_ch1_amp_en(n_ch1_amp_en), .n_ch2_amp_en(n_ch2_amp_en),
    .n_ch3_amp_en(n_ch3_amp_en), .n_ch4_amp_en(n_ch4_amp_en),
    .rmixer(rmixer), .lmixer(lmixer), .n_rvolume(n_rvolume), .n_lvolume(n_lvolume),
    .r_vin_en(r_vin_en), .l_vin_en(l_vin_en),
`ifdef APU_VIN_MIX_EN
    .vin_in(vin_in),
`endif
    .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_valid(pcm_valid), .pdm_l(pdm_l), .pdm_r(pdm_r)
  );

  always #5 cclk = ~cclk;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end else begin
      $display("ok   %s: %0d", tag, actual);
    end
  endtask

  // n_en bit0 = ch1 ... bit3 = ch4
  task automatic set_in(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                        input logic [3:0] a4, input logic [3:0] n_en, input logic [3:0] lm,
                        input logic [3:0] rm, input logic [2:0] nlv, input logic [2:0] nrv);
    ch1_out = a1; ch2_out = a2; ch3_out = a3; ch4_out = a4;
    {n_ch4_amp_en, n_ch3_amp_en, n_ch2_amp_en, n_ch1_amp_en} = n_en;
    lmixer = lm; rmixer = rm; n_lvolume = nlv; n_rvolume = nrv;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(negedge cclk);
      cycles++;
    end while (!pcm_valid && cycles < 200);
    if (!pcm_valid) check("valid_timeout", 0, 1);
  endtask

  // Two valids guarantee the second one comes from a strobe after the inputs were set.
  task automatic sample_check(input string tag, input int exp_l, input int exp_r);
    int c;
    wait_valid(c);
    wait_valid(c);
    check({tag, "_l"}, pcm_l, exp_l);
    check({tag, "_r"}, pcm_r, exp_r);
  endtask

  initial begin
    int cyc;
    int ones_l, ones_r;
    reset = 1'b1; apu_on = 1'b1; r_vin_en = 1'b0; l_vin_en = 1'b0;
`ifdef APU_VIN_MIX_EN
    vin_in = 4'd0;
`endif
    set_in(15, 15, 15, 15, 4'b0000, 4'hF, 4'hF, 3'd0, 3'd0);
    @(negedge cclk);
    check("rst_pcm_l", pcm_l, 0);
    check("rst_pcm_r", pcm_r, 0);
    check("rst_valid", pcm_valid, 0);
    check("rst_pdm_l", pdm_l, 0);
    check("rst_pdm_r", pdm_r, 0);
    reset = 1'b0;
    wait_valid(cyc);
    check("first_valid_lat", cyc, 34);
    check("first_pcm_l", pcm_l, 480);
    check("first_pcm_r", pcm_r, 480);
    @(negedge cclk);
    check("valid_pulse", pcm_valid, 0);

    // asynchronous reset with a sample in stage 1
    repeat (29) @(negedge cclk);
    #2 reset = 1'b1;
    #1;
    check("async_pcm_l", pcm_l, 0);
    check("async_pdm_l", pdm_l, 0);
    check("async_valid", pcm_valid, 0);
    repeat (3) @(negedge cclk);
    reset = 1'b0;
    wait_valid(cyc);
    check("discard_lat", cyc, 34);

    set_in(15, 0, 0, 0, 4'b1110, 4'b0001, 4'b0000, 3'd0, 3'd0);
    sample_check("left_only", 120, 0);
    set_in(15, 15, 15, 15, 4'b0000, 4'hF, 4'hF, 3'd0, 3'd0);
    sample_check("full_pos", 480, 480);
    set_in(0, 0, 0, 0, 4'b0000, 4'hF, 4'hF, 3'd0, 3'd0);
    sample_check("full_neg", -480, -480);
    set_in(0, 0, 0, 0, 4'b0000, 4'hF, 4'hF, 3'd7, 3'd7);
    sample_check("min_vol", -60, -60);
    set_in(0, 0, 0, 0, 4'b1111, 4'hF, 4'hF, 3'd0, 3'd0);
    sample_check("dac_off", 0, 0);
    set_in(10, 7, 3, 8, 4'b0010, 4'b0101, 4'b1010, 3'b010, 3'b110);
    sample_check("mixed", -24, 2);

    // mid-window change of ch1 must not reach the output
    set_in(15, 0, 0, 0, 4'b1110, 4'b0001, 4'b0000, 3'd0, 3'd0);
    sample_check("pre_window", 120, 0);
    ch1_out = 4'd0;
    repeat (20) @(negedge cclk);
    check("window_hold", pcm_l, 120);
    ch1_out = 4'd15;
    wait_valid(cyc);
    check("window_ignored", pcm_l, 120);
    ch1_out = 4'd0;
    wait_valid(cyc);
    check("window_next", pcm_l, -120);

    // apu_on drop clears everything, then restart
    set_in(15, 15, 15, 15, 4'b0000, 4'hF, 4'hF, 3'd0, 3'd0);
    sample_check("pre_off", 480, 480);
    apu_on = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge cclk);
      check("off_pcm_l", pcm_l, 0);
      check("off_pdm_l", pdm_l, 0);
      check("off_valid", pcm_valid, 0);
    end
    set_in(0, 0, 0, 0, 4'b1111, 4'hF, 4'hF, 3'd0, 3'd0);
    apu_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge cclk);
      check("pdm_toggle_l", pdm_l, i % 2);
      check("pdm_toggle_r", pdm_r, i % 2);
    end
    wait_valid(cyc);
    check("restart_lat", cyc + 8, 34);
    check("restart_pcm", pcm_l, 0);

    // sigma-delta density at +480
    set_in(15, 15, 15, 15, 4'b0000, 4'hF, 4'hF, 3'd0, 3'd0);
    sample_check("sd_pre", 480, 480);
    ones_l = 0; ones_r = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge cclk);
      ones_l += int'(pdm_l);
      ones_r += int'(pdm_r);
    end
    check("pdm_ones_l", ones_l, (ones_l >= 1503 && ones_l <= 1505) ? ones_l : 1504);
    check("pdm_ones_r", ones_r, (ones_r >= 1503 && ones_r <= 1505) ? ones_r : 1504);

`ifdef APU_VIN_MIX_EN
    set_in(0, 0, 0, 0, 4'b1111, 4'b0000, 4'b0000, 3'd0, 3'd0);
    vin_in = 4'd15; l_vin_en = 1'b1; r_vin_en = 1'b0;
    sample_check("vin", 120, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
